// File: rtl/matmul_pkg.sv
// Shared constants, FSM state encoding and index helpers for the 4x4 operand sequencer.
package matmul_pkg;

    localparam int DW = 8;
    localparam int RW = 16;
    localparam int N  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] row(input logic [3:0] idx);
        return idx[3:2];
    endfunction

    function automatic logic [1:0] col(input logic [3:0] idx);
        return idx[1:0];
    endfunction

endpackage

// File: rtl/matmul_operand_sequencer_if.sv
// Write port, control, PE operand and result stream signals of the operand sequencer.
interface matmul_operand_sequencer_if;
    import matmul_pkg::*;

    logic          wr_en;
    logic          wr_sel;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] pe_a1, pe_a2, pe_a3, pe_a4;
    logic [DW-1:0] pe_b1, pe_b2, pe_b3, pe_b4;
    logic [RW-1:0] pe_c;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_idx;
    logic [RW-1:0] res_data;

    modport master (
        input  wr_en, wr_sel, wr_addr, wr_data, start, pe_c, res_ready,
        output busy, done, pe_a1, pe_a2, pe_a3, pe_a4, pe_b1, pe_b2, pe_b3, pe_b4,
               res_valid, res_idx, res_data
    );

    modport slave (
        output wr_en, wr_sel, wr_addr, wr_data, start, pe_c, res_ready,
        input  busy, done, pe_a1, pe_a2, pe_a3, pe_a4, pe_b1, pe_b2, pe_b3, pe_b4,
               res_valid, res_idx, res_data
    );

endinterface

// File: rtl/matmul_operand_bank.sv
// 4x4 element register file with one write port and a 4-wide row or column read.
module matmul_operand_bank
    import matmul_pkg::*;
#(
    parameter bit COL_READ = 1'b0
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    rd_sel,
    output logic [DW-1:0] rd_data [N]
);

    logic [DW-1:0] mem [N*N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < N*N; e++) mem[e] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A write in the same cycle is forwarded so start+write loads the new value.
    for (genvar k = 0; k < N; k++) begin : g_rd
        logic [3:0] ra;
        assign ra         = COL_READ ? {2'(k), rd_sel} : {rd_sel, 2'(k)};
        assign rd_data[k] = (we && waddr == ra) ? wdata : mem[ra];
    end

endmodule

// File: rtl/matmul_operand_sequencer.sv
// Walks the 16 (row, col) pairs of C = A x B, feeding the external dot-product PE
// and streaming each result out over a valid/ready port.
//
//  state | meaning
//  IDLE  | banks writable, waiting for start
//  ISSUE | operands on the PE, result settling
//  EMIT  | result offered, waiting for res_ready
//  DONE  | done pulse high, returning to IDLE
module matmul_operand_sequencer
    import matmul_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    matmul_operand_sequencer_if.master   bus
);

    state_t        state;
    logic [3:0]    idx;
    logic [3:0]    ld_idx;
    logic          wr_ok;
    logic [DW-1:0] a_row [N];
    logic [DW-1:0] b_col [N];

    logic          busy_q;
    logic          done_q;
    logic          res_valid_q;
    logic [3:0]    res_idx_q;
    logic [RW-1:0] res_data_q;
    logic [DW-1:0] pe_a_q [N];
    logic [DW-1:0] pe_b_q [N];

    assign wr_ok  = bus.wr_en && (state == IDLE);
    assign ld_idx = (state == IDLE) ? 4'd0 : idx + 4'd1;

    matmul_operand_bank #(.COL_READ(1'b0)) u_bank_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_ok && !bus.wr_sel),
        .waddr   (bus.wr_addr),
        .wdata   (bus.wr_data),
        .rd_sel  (row(ld_idx)),
        .rd_data (a_row)
    );

    matmul_operand_bank #(.COL_READ(1'b1)) u_bank_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_ok && bus.wr_sel),
        .waddr   (bus.wr_addr),
        .wdata   (bus.wr_data),
        .rd_sel  (col(ld_idx)),
        .rd_data (b_col)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
            for (int k = 0; k < N; k++) begin
                pe_a_q[k] <= '0;
                pe_b_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx    <= '0;
                        pe_a_q <= a_row;
                        pe_b_q <= b_col;
                        busy_q <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_data_q  <= bus.pe_c;
                    res_idx_q   <= idx;
                    res_valid_q <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (idx == 4'd15) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            idx    <= ld_idx;
                            pe_a_q <= a_row;
                            pe_b_q <= b_col;
                            state  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_data  = res_data_q;
    assign bus.pe_a1     = pe_a_q[0];
    assign bus.pe_a2     = pe_a_q[1];
    assign bus.pe_a3     = pe_a_q[2];
    assign bus.pe_a4     = pe_a_q[3];
    assign bus.pe_b1     = pe_b_q[0];
    assign bus.pe_b2     = pe_b_q[1];
    assign bus.pe_b3     = pe_b_q[2];
    assign bus.pe_b4     = pe_b_q[3];

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Bench for matmul_operand_sequencer: dot-product PE closed around the DUT,
// results checked against a software matrix product mod 2^16.
module tb_matmul_operand_sequencer;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matmul_operand_sequencer_if bus();

    matmul_operand_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 4-term dot-product PE, truncated to the result width
    assign bus.pe_c = RW'(bus.pe_a1) * RW'(bus.pe_b1) + RW'(bus.pe_a2) * RW'(bus.pe_b2)
                    + RW'(bus.pe_a3) * RW'(bus.pe_b3) + RW'(bus.pe_a4) * RW'(bus.pe_b4);

    typedef struct {
        int idx;
        int data;
    } res_t;

    typedef struct {
        string name;
        int    a_mode;
        int    b_mode;
        bit    rand_ready;
        int    hook;
        int    exp_first;
        int    exp_last;
    } case_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   a_m [16];
    int   b_m [16];
    res_t sb_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int fill(input int mode, input int r, input int c);
        case (mode)
            0:       return (r == c) ? 1 : 0;
            1:       return r*4 + c + 1;
            2:       return 255;
            3:       return r + 1;
            4:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int expc(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += a_m[(n/4)*4 + k] * b_m[k*4 + (n%4)];
        return s % 65536;
    endfunction

    task automatic set_model(input int a_mode, input int b_mode);
        for (int e = 0; e < 16; e++) begin
            a_m[e] = fill(a_mode, e/4, e%4);
            b_m[e] = fill(b_mode, e/4, e%4);
        end
    endtask

    task automatic load_mats();
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 16; e++) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = s[0];
                bus.wr_addr = 4'(e);
                bus.wr_data = 8'((s == 0) ? a_m[e] : b_m[e]);
                @(negedge clk);
            end
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},      int'(bus.busy), 0);
        chk({pfx, "_done"},      int'(bus.done), 0);
        chk({pfx, "_res_valid"}, int'(bus.res_valid), 0);
        chk({pfx, "_res_idx"},   int'(bus.res_idx), 0);
        chk({pfx, "_res_data"},  int'(bus.res_data), 0);
        chk({pfx, "_pe_a"},      int'({bus.pe_a1, bus.pe_a2, bus.pe_a3, bus.pe_a4}), 0);
        chk({pfx, "_pe_b"},      int'({bus.pe_b1, bus.pe_b2, bus.pe_b3, bus.pe_b4}), 0);
    endtask

    // hook: 0 none, 1 start+write mid-run, 2 reset after result 7, 3 write with start
    task automatic run_mat(input bit rand_ready, input int hook,
                           output int first_data, output int last_data);
        int          cyc, nres;
        bit          fin, stalled, saw_done;
        logic [19:0] p_res;
        logic [31:0] p_a, p_b;
        res_t        e;
        first_data = -1;
        last_data  = -1;
        nres       = 0;
        fin        = 1'b0;
        stalled    = 1'b0;
        for (int n = 0; n < 16; n++) sb_q.push_back('{n, expc(n)});
        bus.start = 1'b1;
        if (hook == 3) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'd5;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        cyc = 1;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("valid_not_yet", int'(bus.res_valid), 0);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) chk("first_valid_latency", int'(bus.res_valid), 1);
            if (stalled) begin
                chk("stall_hold_res", int'({bus.res_idx, bus.res_data}), int'(p_res));
                chk("stall_hold_pe_a", int'({bus.pe_a1, bus.pe_a2, bus.pe_a3, bus.pe_a4}), int'(p_a));
                chk("stall_hold_pe_b", int'({bus.pe_b1, bus.pe_b2, bus.pe_b3, bus.pe_b4}), int'(p_b));
            end
            if (bus.done) begin
                fin = 1'b1;
                chk("done_result_count", nres, 16);
                chk("done_sb_empty", sb_q.size(), 0);
                chk("busy_low_at_done", int'(bus.busy), 0);
                if (!rand_ready) chk("done_cycle", cyc, 33);
                @(negedge clk);
                chk("done_pulse_width", int'(bus.done), 0);
            end else if (cyc > 400) begin
                chk("run_timeout", 0, 1);
                fin = 1'b1;
            end else if (hook == 2 && nres == 7) begin
                rst_n = 1'b0;
                bus.res_ready = 1'b0;
                @(negedge clk);
                chk_zero("midrun_reset");
                rst_n = 1'b1;
                saw_done = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (bus.done || bus.busy) saw_done = 1'b1;
                end
                chk("no_done_after_reset", int'(saw_done), 0);
                sb_q.delete();
                fin = 1'b1;
            end else begin
                if (hook == 1 && cyc == 5) begin
                    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
                    bus.wr_addr = 4'd0; bus.wr_data = 8'd99;
                end else if (hook == 1 && cyc == 6) begin
                    bus.start = 1'b0; bus.wr_en = 1'b0;
                end
                bus.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                stalled = bus.res_valid && !bus.res_ready;
                p_res   = {bus.res_idx, bus.res_data};
                p_a     = {bus.pe_a1, bus.pe_a2, bus.pe_a3, bus.pe_a4};
                p_b     = {bus.pe_b1, bus.pe_b2, bus.pe_b3, bus.pe_b4};
                if (bus.res_valid && bus.res_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("res_idx[%0d]", e.idx), int'(bus.res_idx), e.idx);
                        chk($sformatf("res_data[%0d]", e.idx), int'(bus.res_data), e.data);
                    end
                    nres++;
                    if (nres == 1) first_data = int'(bus.res_data);
                    last_data = int'(bus.res_data);
                end
            end
        end
        bus.res_ready = 1'b0;
    endtask

    case_t cases [4];
    int    fd, ld;

    initial begin
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_sel    = 1'b0;
        bus.wr_addr   = 4'd0;
        bus.wr_data   = 8'd0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        cases[0] = '{"identity_seq",   0, 1, 1'b0, 0, 1,     16};
        cases[1] = '{"all255_wrap",    2, 2, 1'b0, 0, 63492, 63492};
        cases[2] = '{"rowscale_stall", 3, 4, 1'b1, 0, 8,     32};
        cases[3] = '{"busy_lockout",   0, 1, 1'b0, 1, 1,     16};
        for (int t = 0; t < 4; t++) begin
            set_model(cases[t].a_mode, cases[t].b_mode);
            load_mats();
            run_mat(cases[t].rand_ready, cases[t].hook, fd, ld);
            chk({cases[t].name, "_first"}, fd, cases[t].exp_first);
            chk({cases[t].name, "_last"},  ld, cases[t].exp_last);
            repeat (2) @(negedge clk);
        end

        // reset partway through, then run on the cleared banks
        set_model(0, 1);
        load_mats();
        run_mat(1'b0, 2, fd, ld);
        set_model(5, 5);
        run_mat(1'b0, 0, fd, ld);
        chk("zero_banks_first", fd, 0);
        chk("zero_banks_last",  ld, 0);
        repeat (2) @(negedge clk);

        // write of A[0]=5 coinciding with start
        set_model(0, 1);
        load_mats();
        a_m[0] = 5;
        run_mat(1'b0, 3, fd, ld);
        chk("write_with_start_c00", fd, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
